fnd_mode_scheduler: RTL

//  Sequences which source the 4-digit FND shows: stopwatch sec.msec, watch hour:min,
//  SR04 distance or DHT11 reading. Advances on a user button pulse or on an auto-rotate

---
 rtl/fnd_mode_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fnd_mode_scheduler.sv
// FND source sequencer: stopwatch / watch / SR04 / DHT11 with blanking and sensor freshness.
// Optional FND_SCHED_SKIP_STALE_EN: advance skips sensor modes whose data is stale.
module fnd_mode_scheduler #(
  parameter int TICK_DIV  = 100_000,
  parameter int ROTATE_MS = 3000,
  parameter int BLANK_MS  = 100,
  parameter int HOLD_MS   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_next,
  input  logic       i_auto_en,
  input  logic       i_sr04_valid,
  input  logic       i_dht11_valid,
  output logic [1:0] o_mode,
  output logic       o_sel_display,
  output logic       o_sel_sensor,
  output logic       o_sw_3,
  output logic       o_blank,
  output logic [1:0] o_stale
);

  // state | meaning
  // SHOW  | o_mode on display, rotate timer running while auto enabled
  // BLANK | digits forced off, waiting BLANK_MS before committing pending mode

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(ROTATE_MS + 1);
  localparam int BW = $clog2(BLANK_MS + 1);
  localparam int HW = $clog2(HOLD_MS + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] ROT_MAX   = RW'(ROTATE_MS - 1);
  localparam logic [BW-1:0] BLK_MAX   = BW'(BLANK_MS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_MS);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(HOLD_MS - 1);

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic          tick;
  logic [RW-1:0] rot_cnt;
  logic [BW-1:0] blk_cnt;
  logic [HW-1:0] hold_cnt [2];
  logic [1:0]    pend_mode;
  logic [1:0]    cand_mode;
  logic          req;
  logic          blank_done;
  logic [1:0]    valid;

  assign tick  = (presc == PRESC_MAX);
  assign valid = {i_dht11_valid, i_sr04_valid};

  always_comb begin
    state_nxt  = state;
    req        = 1'b0;
    blank_done = 1'b0;
    case (state)
      SHOW: begin
        req = i_btn_next | (tick & i_auto_en & (rot_cnt == ROT_MAX));
        if (req) state_nxt = BLANK;
      end
      BLANK: begin
        blank_done = tick & (blk_cnt == BLK_MAX);
        if (blank_done) state_nxt = SHOW;
      end
      default: state_nxt = SHOW;
    endcase
  end

`ifdef FND_SCHED_SKIP_STALE_EN
  logic [1:0] probe;
  logic       found;

  // Modes 0/1 always qualify, so the search only falls back to o_mode
  // in principle; a stale sensor mode is passed over.
  always_comb begin
    cand_mode = o_mode;
    found     = 1'b0;
    probe     = o_mode;
    for (int i = 1; i < 4; i++) begin
      probe = o_mode + 2'(i);
      if (!found && (!probe[1] || !o_stale[probe[0]])) begin
        cand_mode = probe;
        found     = 1'b1;
      end
    end
  end
`else
  always_comb begin
    cand_mode = o_mode + 2'd1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SHOW;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_mode        <= 2'd0;
      o_blank       <= 1'b0;
      o_sel_display <= 1'b0;
      o_sel_sensor  <= 1'b0;
      o_sw_3        <= 1'b0;
      rot_cnt       <= '0;
      blk_cnt       <= '0;
      pend_mode     <= 2'd0;
    end else begin
      case (state)
        SHOW: begin
          if (req) begin
            o_blank   <= 1'b1;
            blk_cnt   <= '0;
            rot_cnt   <= '0;
            pend_mode <= cand_mode;
          end else if (!i_auto_en) begin
            rot_cnt <= '0;
          end else if (tick) begin
            rot_cnt <= rot_cnt + 1'b1;
          end
        end
        BLANK: begin
          rot_cnt <= '0;
          if (blank_done) begin
            o_mode        <= pend_mode;
            o_blank       <= 1'b0;
            o_sel_display <= (pend_mode == 2'd1);
            o_sel_sensor  <= (pend_mode == 2'd3);
            o_sw_3        <= pend_mode[1];
          end else if (tick) begin
            blk_cnt <= blk_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Freshness counters saturate at HOLD_MS; a valid pulse beats a coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_stale <= 2'b11;
      for (int i = 0; i < 2; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (valid[i]) begin
          hold_cnt[i] <= '0;
          o_stale[i]  <= 1'b0;
        end else if (tick && (hold_cnt[i] != HOLD_MAX)) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
          if (hold_cnt[i] == HOLD_PRE) o_stale[i] <= 1'b1;
        end
      end
    end
  end

endmodule
